// File: rtl/display_pkg.sv
// Shared widths, pixel type and config clamp helper for the display frame-buffer datapath.
package display_pkg;

    localparam int PIX_W     = 24;
    localparam int MAX_PIX   = 110;
    localparam int MAX_LINES = 110;
    localparam int LINE_W    = PIX_W * MAX_PIX;

    typedef logic [PIX_W-1:0] pixel_t;

    localparam pixel_t BLANK_PIX = 24'h0;

    // Shrinks the active count so active+blank fits in the limit; a blank alone
    // that already fills the limit leaves no active area at all.
    function automatic logic [10:0] clamp_active(
        input logic [9:0]  active,
        input logic [9:0]  blank,
        input logic [10:0] limit
    );
        logic [10:0] sum;
        sum = {1'b0, active} + {1'b0, blank};
        if (sum <= limit) begin
            return {1'b0, active};
        end
        if ({1'b0, blank} >= limit) begin
            return 11'd0;
        end
        return limit - {1'b0, blank};
    endfunction

endpackage

// File: rtl/frame_buffer_ram.sv
// Frame store: one pixel write port, one whole-line combinational read port.
module frame_buffer_ram
    import display_pkg::*;
(
    input  logic   clk,
    input  logic   we,
    input  logic [6:0] wr_row,
    input  logic [6:0] wr_col,
    input  pixel_t wr_data,
    input  logic [6:0] rd_row,
    output pixel_t rd_line [MAX_PIX]
);

    pixel_t mem [MAX_LINES][MAX_PIX];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    always_comb begin
        for (int p = 0; p < MAX_PIX; p++) begin
            rd_line[p] = mem[rd_row][p];
        end
    end

endmodule

// File: rtl/display_data_path.sv
// Frame-buffer datapath: host pixel load, then padded line-by-line readout to the line writer.
module display_data_path
    import display_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       WData,
    input  logic [9:0]        HBOut_PD,
    input  logic [9:0]        VBOut_PD,
    input  logic [9:0]        AIPOut_PD,
    input  logic [9:0]        AILOut_PD,
    input  logic              CSDisplay,
    input  logic              readFrame,
    input  logic              FrameReadResetLine,
    input  logic              FrameReadIncLine,
    output logic [0:LINE_W-1] FrameDataOut
);

    logic [10:0] aip_eff;
    logic [10:0] ail_eff;
    logic [10:0] lines_total;
    logic [10:0] wr_col;
    logic [10:0] wr_row;
    logic [10:0] line_ptr;
    logic [10:0] line_next;
    logic [10:0] line_inc;
    logic        image_full;
    logic        wr_en;
    logic        line_active;
    logic [6:0]  rd_row;
    pixel_t      rd_line [MAX_PIX];
    logic [0:LINE_W-1] line_data;
    logic        unused_hi;

    assign unused_hi = ^WData[31:24];

    assign aip_eff     = clamp_active(AIPOut_PD, HBOut_PD, 11'(MAX_PIX));
    assign ail_eff     = clamp_active(AILOut_PD, VBOut_PD, 11'(MAX_LINES));
    assign lines_total = ail_eff + {1'b0, VBOut_PD};

    // Column guard also covers a zero-width line, where nothing may be written.
    assign image_full = (wr_row >= ail_eff);
    assign wr_en      = !reset && !CSDisplay && !readFrame && !image_full && (wr_col < aip_eff);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_col <= '0;
            wr_row <= '0;
        end else if (CSDisplay) begin
            wr_col <= '0;
            wr_row <= '0;
        end else if (wr_en) begin
            if (wr_col == aip_eff - 11'd1) begin
                wr_col <= '0;
                wr_row <= wr_row + 11'd1;
            end else begin
                wr_col <= wr_col + 11'd1;
            end
        end
    end

    assign line_inc = line_ptr + 11'd1;

    always_comb begin
        line_next = line_ptr;
        if (FrameReadResetLine) begin
            line_next = '0;
        end else if (FrameReadIncLine) begin
            line_next = (line_inc >= lines_total) ? 11'd0 : line_inc;
        end
    end

    // Blank lines beyond the store never touch the RAM; park the address at 0.
    assign rd_row      = (line_next < 11'(MAX_LINES)) ? line_next[6:0] : 7'd0;
    assign line_active = (line_next < ail_eff);

    frame_buffer_ram u_ram (
        .clk     (clk),
        .we      (wr_en),
        .wr_row  (wr_row[6:0]),
        .wr_col  (wr_col[6:0]),
        .wr_data (WData[PIX_W-1:0]),
        .rd_row  (rd_row),
        .rd_line (rd_line)
    );

    always_comb begin
        line_data = '0;
        for (int p = 0; p < MAX_PIX; p++) begin
            line_data[PIX_W*p +: PIX_W] = (line_active && (11'(p) < aip_eff)) ? rd_line[p] : BLANK_PIX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_ptr     <= '0;
            FrameDataOut <= '0;
        end else if (readFrame) begin
            line_ptr     <= line_next;
            FrameDataOut <= line_data;
        end
    end

endmodule

// File: tb/tb_display_data_path.sv
// Scoreboard bench for display_data_path: directed load/readout vectors with hand-derived expectations.
module tb_display_data_path;
    import display_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       WData;
    logic [9:0]        HBOut_PD;
    logic [9:0]        VBOut_PD;
    logic [9:0]        AIPOut_PD;
    logic [9:0]        AILOut_PD;
    logic              CSDisplay;
    logic              readFrame;
    logic              FrameReadResetLine;
    logic              FrameReadIncLine;
    logic [0:LINE_W-1] FrameDataOut;

    display_data_path dut (
        .clk                (clk),
        .reset              (reset),
        .WData              (WData),
        .HBOut_PD           (HBOut_PD),
        .VBOut_PD           (VBOut_PD),
        .AIPOut_PD          (AIPOut_PD),
        .AILOut_PD          (AILOut_PD),
        .CSDisplay          (CSDisplay),
        .readFrame          (readFrame),
        .FrameReadResetLine (FrameReadResetLine),
        .FrameReadIncLine   (FrameReadIncLine),
        .FrameDataOut       (FrameDataOut)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference image as the host has written it
    int model [MAX_LINES][MAX_PIX];
    int mw_r = 0;
    int mw_c = 0;
    int m_aip = 100;
    int m_ail = 100;

    int                n_vec = 0;
    int                n_err = 0;
    int                q_cyc  [$];
    string             q_name [$];
    int                q_pix  [$];
    int                q_val  [$];
    logic [0:LINE_W-1] q_line [$];

    function automatic logic [0:LINE_W-1] exp_line(input int l, input int aip, input int ail);
        logic [0:LINE_W-1] v;
        v = '0;
        for (int p = 0; p < MAX_PIX; p++) begin
            if (l < ail && p < aip) v[PIX_W*p +: PIX_W] = 24'(model[l][p]);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset || CSDisplay) begin
            mw_r = 0;
            mw_c = 0;
        end else if (!readFrame && mw_r < m_ail) begin
            model[mw_r][mw_c] = int'(WData[23:0]);
            if (mw_c == m_aip - 1) begin
                mw_c = 0;
                mw_r++;
            end else begin
                mw_c++;
            end
        end
        #1;
    endtask

    task automatic expect_vec(input string name, input logic [0:LINE_W-1] v);
        q_cyc.push_back(cyc);
        q_name.push_back(name);
        q_pix.push_back(-1);
        q_val.push_back(0);
        q_line.push_back(v);
    endtask

    task automatic expect_line(input string name, input int l, input int aip, input int ail);
        expect_vec(name, exp_line(l, aip, ail));
    endtask

    task automatic expect_pix(input string name, input int p, input int v);
        q_cyc.push_back(cyc);
        q_name.push_back(name);
        q_pix.push_back(p);
        q_val.push_back(v);
        q_line.push_back('0);
    endtask

    always @(negedge clk) begin
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            int                c;
            string             nm;
            int                p;
            int                v;
            logic [0:LINE_W-1] l;
            c  = q_cyc.pop_front();
            nm = q_name.pop_front();
            p  = q_pix.pop_front();
            v  = q_val.pop_front();
            l  = q_line.pop_front();
            n_vec++;
            if (c != cyc) begin
                n_err++;
                $display("FAIL %s: checked at cycle %0d, due at cycle %0d", nm, cyc, c);
            end else if (p < 0) begin
                if (FrameDataOut !== l) begin
                    int bad;
                    bad = 0;
                    for (int i = MAX_PIX - 1; i >= 0; i--) begin
                        if (FrameDataOut[PIX_W*i +: PIX_W] !== l[PIX_W*i +: PIX_W]) bad = i;
                    end
                    n_err++;
                    $display("FAIL %s: pixel %0d got %h want %h", nm, bad,
                             FrameDataOut[PIX_W*bad +: PIX_W], l[PIX_W*bad +: PIX_W]);
                end
            end else if (FrameDataOut[PIX_W*p +: PIX_W] !== 24'(v)) begin
                n_err++;
                $display("FAIL %s: pixel %0d got %h want %h", nm, p,
                         FrameDataOut[PIX_W*p +: PIX_W], 24'(v));
            end
        end
    end

    initial begin
        logic [0:LINE_W-1] held;
        reset = 1'b1;
        WData = '0;
        HBOut_PD = 10'd10;
        VBOut_PD = 10'd10;
        AIPOut_PD = 10'd100;
        AILOut_PD = 10'd100;
        CSDisplay = 1'b0;
        readFrame = 1'b0;
        FrameReadResetLine = 1'b0;
        FrameReadIncLine = 1'b0;
        tick();
        tick();
        expect_vec("reset_state", '0);

        // full 100x100 load, upper data byte is junk
        reset = 1'b0;
        for (int r = 0; r < 100; r++) begin
            for (int c = 0; c < 100; c++) begin
                WData = {8'hA5, 24'(r * 100 + c)};
                tick();
            end
        end
        WData = 32'hFFFF_FFFF;
        repeat (3) tick();

        CSDisplay = 1'b1;
        readFrame = 1'b1;
        FrameReadResetLine = 1'b1;
        tick();
        expect_line("line0", 0, 100, 100);
        expect_pix("l0_px0", 0, 0);
        expect_pix("l0_px99", 99, 99);
        expect_pix("l0_px100", 100, 0);
        expect_pix("l0_px109", 109, 0);

        FrameReadResetLine = 1'b0;
        FrameReadIncLine = 1'b1;
        for (int l = 1; l < 110; l++) begin
            tick();
            expect_line("line_step", l, 100, 100);
            if (l < 100) expect_pix("lx_px0", 0, 100 * l);
            if (l == 99) expect_pix("l99_px5", 5, 9905);
        end
        tick();
        expect_line("wrap_line0", 0, 100, 100);

        readFrame = 1'b0;
        WData = 32'h0012_3456;
        repeat (3) begin
            tick();
            expect_line("hold_rf0", 0, 100, 100);
        end
        readFrame = 1'b1;
        FrameReadIncLine = 1'b0;
        tick();
        expect_line("ptr_held", 0, 100, 100);
        FrameReadIncLine = 1'b1;
        tick();
        expect_line("inc_to_1", 1, 100, 100);
        FrameReadResetLine = 1'b1;
        tick();
        expect_line("reset_wins", 0, 100, 100);
        FrameReadResetLine = 1'b0;
        FrameReadIncLine = 1'b0;

        // partial load interrupted by the display taking the buffer
        readFrame = 1'b0;
        CSDisplay = 1'b0;
        for (int i = 0; i < 9997; i++) begin
            WData = 32'(50000 + i);
            tick();
        end
        CSDisplay = 1'b1;
        tick();
        CSDisplay = 1'b0;
        WData = 32'h0012_3456;
        tick();
        CSDisplay = 1'b1;
        readFrame = 1'b1;
        FrameReadResetLine = 1'b1;
        tick();
        expect_line("restart_l0", 0, 100, 100);
        expect_pix("restart_px0", 0, 24'h123456);
        expect_pix("restart_px1", 1, 50001);
        FrameReadResetLine = 1'b0;
        FrameReadIncLine = 1'b1;
        repeat (99) tick();
        FrameReadIncLine = 1'b0;
        expect_line("partial_l99", 99, 100, 100);
        expect_pix("partial_px96", 96, 59996);
        expect_pix("partial_px97", 97, 9997);
        expect_pix("partial_px99", 99, 9999);

        reset = 1'b1;
        tick();
        expect_vec("rst_mid_read", '0);
        reset = 1'b0;
        FrameReadResetLine = 1'b1;
        tick();
        expect_line("read_after_rst", 0, 100, 100);
        held = exp_line(0, 100, 100);
        FrameReadResetLine = 1'b0;
        readFrame = 1'b0;
        CSDisplay = 1'b0;
        for (int i = 0; i < 5; i++) begin
            WData = 32'(24'h0A0000 + i);
            tick();
        end
        expect_vec("hold_during_load", held);
        reset = 1'b1;
        WData = 32'h00DE_ADBE;
        tick();
        expect_vec("rst_mid_load", '0);
        reset = 1'b0;
        WData = 32'h0077_7777;
        tick();
        CSDisplay = 1'b1;
        readFrame = 1'b1;
        FrameReadResetLine = 1'b1;
        tick();
        expect_line("after_rst_l0", 0, 100, 100);
        expect_pix("after_rst_px0", 0, 24'h777777);
        expect_pix("after_rst_px1", 1, 24'h0A0001);

        // blanking that no longer fits forces the active area down to 90x90
        HBOut_PD = 10'd20;
        VBOut_PD = 10'd20;
        tick();
        expect_line("clamp_l0", 0, 90, 90);
        expect_pix("clamp_px90", 90, 0);
        FrameReadResetLine = 1'b0;
        FrameReadIncLine = 1'b1;
        repeat (90) tick();
        FrameReadIncLine = 1'b0;
        expect_line("clamp_l90", 90, 90, 90);
        expect_pix("clamp_l90_px0", 0, 0);

        repeat (2) tick();
        if (q_cyc.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q_cyc.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
